// File: rtl/par_bus_pkg.sv
// Shared definitions for the parallel bus slave: FSM encoding, default sync
// pattern and the bus opcode values carried in the received byte stream.
package par_bus_pkg;

  typedef enum logic [1:0] {
    ST_HUNT0  = 2'd0,
    ST_HUNT1  = 2'd1,
    ST_SYNCED = 2'd2
  } bus_state_e;

  localparam logic [7:0] SYNC_WORD0_DEF = 8'hB8;
  localparam logic [7:0] SYNC_WORD1_DEF = 8'h8B;

  localparam logic [7:0] OP_SET_HASH   = 8'h01;
  localparam logic [7:0] OP_SEND_TEXT  = 8'h02;
  localparam logic [7:0] OP_READ_MATCH = 8'h03;
  localparam logic [7:0] OP_TEST       = 8'h04;
  localparam logic [7:0] OP_STR_LEN    = 8'h05;

endpackage

// File: rtl/par_bus_slave_if.sv
// Word stream handshake. A transfer happens in a cycle where valid and ready
// are both high; the master holds data stable while valid is high and not
// accepted. Exception used by sync_fifo: ready on its read side while the
// FIFO is empty takes the word being written in the same cycle.
interface par_bus_slave_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush. A write while full is
// taken when a read fires in the same cycle; a read while empty takes the
// word written in the same cycle. Either way the occupancy is unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  par_bus_slave_if.slave   wr,
  par_bus_slave_if.master  rd
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty, full, wr_fire, rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign wr.ready = ~full;
  assign rd.valid = ~empty;
  assign rd.data  = empty ? wr.data : mem_q[rd_ptr_q];
  assign rd_fire  = rd.ready & (~empty | wr.valid);
  assign wr_fire  = wr.valid & (~full | rd_fire);

  // Next pointer and occupancy; flush empties the FIFO and wins over traffic
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q;
    if (wr_fire && !rd_fire) count_d = count_q + 1'b1;
    if (!wr_fire && rd_fire) count_d = count_q - 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr.data;
  end

endmodule

// File: rtl/par_bus_slave.sv
// Parallel bus slave: synchronises an external strobe bus, hunts for a
// two-word sync pattern, then moves master writes into an RX FIFO and serves
// master reads from a TX FIFO.
module par_bus_slave
  import par_bus_pkg::*;
#(
  parameter int         DATA_WIDTH  = 8,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] SYNC_WORD0  = SYNC_WORD0_DEF,
  parameter logic [7:0] SYNC_WORD1  = SYNC_WORD1_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_clk,
  input  logic                  bus_rnw,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  synced,
  input  logic                  resync,
  output logic                  rx_overflow,
  output logic                  tx_underflow,
  input  logic                  clear_flags
);
  localparam logic [DATA_WIDTH-1:0] SW0 = DATA_WIDTH'(SYNC_WORD0);
  localparam logic [DATA_WIDTH-1:0] SW1 = DATA_WIDTH'(SYNC_WORD1);

  logic [SYNC_STAGES-1:0] bclk_sync_q, rnw_sync_q;
  logic [DATA_WIDTH-1:0]  data_sync_q [SYNC_STAGES];
  logic                   bclk_s, rnw_s;
  logic [DATA_WIDTH-1:0]  data_s;
  logic                   bclk_prev_q, rise_q, fall_q, rnw_e_q;
  logic [DATA_WIDTH-1:0]  data_e_q;
  bus_state_e             state_q, state_d;
  logic                   synced_q, flush;
  logic                   rx_push_due, rx_pop_fire, tx_pop_due;
  logic                   rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d, oe_q, oe_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;

  par_bus_slave_if #(.W(DATA_WIDTH)) rx_wr ();
  par_bus_slave_if #(.W(DATA_WIDTH)) rx_rd ();
  par_bus_slave_if #(.W(DATA_WIDTH)) tx_wr ();
  par_bus_slave_if #(.W(DATA_WIDTH)) tx_rd ();

  // Pad synchronisers; the strobe idles high so its stages reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '1;
      rnw_sync_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      bclk_sync_q    <= {bclk_sync_q[SYNC_STAGES-2:0], bus_clk};
      rnw_sync_q     <= {rnw_sync_q[SYNC_STAGES-2:0], bus_rnw};
      data_sync_q[0] <= bus_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign rnw_s  = rnw_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // One-cycle strobe edge pulses, with data and direction aligned to them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      rnw_e_q     <= 1'b0;
      data_e_q    <= '0;
    end else begin
      bclk_prev_q <= bclk_s;
      rise_q      <= bclk_s & ~bclk_prev_q;
      fall_q      <= ~bclk_s & bclk_prev_q;
      rnw_e_q     <= rnw_s;
      data_e_q    <= data_s;
    end
  end

  // Sync hunt: next state from the synchronised strobe level and data
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HUNT0:  if (bclk_s && data_s == SW0) state_d = ST_HUNT1;
      ST_HUNT1: begin
        if (bclk_s && data_s == SW1)            state_d = ST_SYNCED;
        else if (data_s != SW0 && data_s != SW1) state_d = ST_HUNT0;
      end
      ST_SYNCED: if (resync) state_d = ST_HUNT0;
      default:   state_d = ST_HUNT0;
    endcase
  end

  // FSM state with its registered synced output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HUNT0;
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      synced_q <= (state_d == ST_SYNCED);
    end
  end

  assign flush       = (state_q == ST_SYNCED) & resync;
  assign rx_push_due = (state_q == ST_SYNCED) & rise_q & ~rnw_e_q;
  assign tx_pop_due  = (state_q == ST_SYNCED) & fall_q & rnw_e_q;

  assign rx_wr.valid = rx_push_due;
  assign rx_wr.data  = data_e_q;
  assign rx_pop_fire = rx_ready & rx_rd.valid;
  assign rx_rd.ready = rx_pop_fire;
  assign tx_wr.valid = tx_valid & tx_wr.ready;
  assign tx_wr.data  = tx_data;
  assign tx_rd.ready = tx_pop_due;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset), .flush(flush), .wr(rx_wr), .rd(rx_rd)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset), .flush(flush), .wr(tx_wr), .rd(tx_rd)
  );

  // Sticky error flags, read data register and pad output enable
  always_comb begin
    rx_ovf_d = (rx_ovf_q & ~clear_flags) | (rx_push_due & ~rx_wr.ready & ~rx_pop_fire);
    tx_unf_d = (tx_unf_q & ~clear_flags) | (tx_pop_due & ~tx_rd.valid & ~tx_wr.valid);
    dout_d   = dout_q;
    if (tx_pop_due) dout_d = (tx_rd.valid | tx_wr.valid) ? tx_rd.data : '0;
    oe_d     = synced_q & rnw_s;
  end

  // Registers behind the status and pad outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
      dout_q   <= '0;
      oe_q     <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_unf_q <= tx_unf_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  assign bus_data_out = dout_q;
  assign bus_data_oe  = oe_q;
  assign rx_data      = rx_rd.data;
  assign rx_valid     = rx_rd.valid;
  assign tx_ready     = tx_wr.ready;
  assign synced       = synced_q;
  assign rx_overflow  = rx_ovf_q;
  assign tx_underflow = tx_unf_q;

endmodule

// File: tb/tb_par_bus_slave.sv
// Bench for par_bus_slave: drives the strobe bus slowly relative to clk and
// checks the RX/TX streams against expected-word queues.
module tb_par_bus_slave;
  import par_bus_pkg::*;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int SS     = 2;
  localparam int SETTLE = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bus_clk = 1'b1;
  logic          bus_rnw = 1'b0;
  logic [DW-1:0] bus_data_in = '0;
  logic [DW-1:0] bus_data_out;
  logic          bus_data_oe;
  logic          synced;
  logic          resync = 1'b0;
  logic          rx_overflow, tx_underflow;
  logic          clear_flags = 1'b0;

  par_bus_slave_if #(.W(DW)) rx_if ();
  par_bus_slave_if #(.W(DW)) tx_if ();

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_exp_q[$];
  int            rx_cnt = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  par_bus_slave #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset),
    .bus_clk(bus_clk), .bus_rnw(bus_rnw), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .rx_data(rx_if.data), .rx_valid(rx_if.valid), .rx_ready(rx_if.ready),
    .tx_data(tx_if.data), .tx_valid(tx_if.valid), .tx_ready(tx_if.ready),
    .synced(synced), .resync(resync),
    .rx_overflow(rx_overflow), .tx_underflow(tx_underflow),
    .clear_flags(clear_flags)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input logic c, input logic [DW-1:0] d, input logic rnw);
    bus_clk     = c;
    bus_data_in = d;
    bus_rnw     = rnw;
    tick(SETTLE);
  endtask

  // Master write strobe; the model decides whether RX has room for it
  task automatic bus_write(input logic [DW-1:0] d);
    bus_drive(1'b0, d, 1'b0);
    bus_drive(1'b1, d, 1'b0);
    if (rx_cnt < DEPTH) begin
      exp_q.push_back(d);
      rx_cnt++;
    end
  endtask

  // Master read strobe; the word lands on the fall
  task automatic bus_read(input string tag);
    logic [DW-1:0] e;
    e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : '0;
    bus_drive(1'b0, bus_data_in, 1'b1);
    check({tag, "_dout"}, bus_data_out, e);
    check({tag, "_oe"}, bus_data_oe, 1'b1);
    bus_drive(1'b1, bus_data_in, 1'b1);
  endtask

  task automatic rx_pop(input string tag);
    logic [DW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_valid"}, rx_if.valid, 1'b1);
    check({tag, "_data"}, rx_if.data, e);
    rx_if.ready = 1'b1;
    tick(1);
    rx_if.ready = 1'b0;
    rx_cnt--;
  endtask

  task automatic tx_push(input logic [DW-1:0] d);
    tx_if.data  = d;
    tx_if.valid = 1'b1;
    tick(1);
    tx_if.valid = 1'b0;
    tx_exp_q.push_back(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, rx_if.valid, 1'b0);
    check({tag, "_tx_ready"}, tx_if.ready, 1'b1);
    check({tag, "_synced"}, synced, 1'b0);
    check({tag, "_oe"}, bus_data_oe, 1'b0);
    check({tag, "_dout"}, bus_data_out, '0);
    check({tag, "_ovf"}, rx_overflow, 1'b0);
    check({tag, "_unf"}, tx_underflow, 1'b0);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] head;
    rx_if.ready = 1'b0;
    tx_if.valid = 1'b0;
    tx_if.data  = '0;

    // Reset state
    #2;
    check_reset_outputs("por");
    check("por_state", 32'(dut.state_q), 32'(ST_HUNT0));
    tick(3);
    reset = 1'b0;
    tick(2);

    // Sync, then one write with latency measurement
    bus_drive(1'b1, 8'hB8, 1'b0);
    check("hunt1", 32'(dut.state_q), 32'(ST_HUNT1));
    check("hunt1_synced", synced, 1'b0);
    bus_drive(1'b1, 8'h8B, 1'b0);
    check("sync_ok", synced, 1'b1);
    bus_drive(1'b0, OP_SET_HASH, 1'b0);
    bus_clk = 1'b1;
    lat = 0;
    while (lat < 12 && !rx_if.valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rx_latency", lat, SS + 2);
    exp_q.push_back(OP_SET_HASH);
    rx_cnt++;
    tick(2);
    rx_pop("w01");
    check("w01_empty", rx_if.valid, 1'b0);

    // Wrong sync sequence
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    tick(1);
    check("resync0_synced", synced, 1'b0);
    bus_drive(1'b1, 8'hB8, 1'b0);
    check("ws_b8", 32'(dut.state_q), 32'(ST_HUNT1));
    bus_drive(1'b1, 8'h55, 1'b0);
    check("ws_55", 32'(dut.state_q), 32'(ST_HUNT0));
    check("ws_55_synced", synced, 1'b0);
    bus_drive(1'b1, 8'hB8, 1'b0);
    check("ws_b8b", 32'(dut.state_q), 32'(ST_HUNT1));
    check("ws_b8b_synced", synced, 1'b0);
    bus_drive(1'b1, 8'h8B, 1'b0);
    check("ws_8b_synced", synced, 1'b1);

    // Overflow: 17 writes with no reads
    for (int i = 0; i <= DEPTH; i++) bus_write(DW'(i));
    check("ovf_flag", rx_overflow, 1'b1);
    check("ovf_tx_ready", tx_if.ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) rx_pop($sformatf("ovf_%0d", i));
    check("ovf_lost", rx_if.valid, 1'b0);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("ovf_clear", rx_overflow, 1'b0);

    // Full boundary: pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) bus_write(DW'(8'h20 + i));
    check("full_count", 32'(dut.u_rx_fifo.count_q), DEPTH);
    bus_drive(1'b0, 8'h30, 1'b0);
    bus_clk = 1'b1;
    tick(3);
    head = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("full_head", rx_if.data, head);
    rx_if.ready = 1'b1;
    tick(1);
    rx_if.ready = 1'b0;
    exp_q.push_back(8'h30);
    tick(3);
    check("full_no_ovf", rx_overflow, 1'b0);
    check("full_count_kept", 32'(dut.u_rx_fifo.count_q), DEPTH);
    for (int i = 0; i < DEPTH; i++) rx_pop($sformatf("full_%0d", i));
    check("full_drained", rx_if.valid, 1'b0);

    // Reads: two queued words then an underflow
    tx_push(8'hA5);
    tx_push(8'h5A);
    tx_exp_q.push_back(8'h00);
    bus_drive(1'b1, 8'h30, 1'b1);
    check("rd_oe", bus_data_oe, 1'b1);
    bus_read("rd0");
    check("rd0_unf", tx_underflow, 1'b0);
    bus_read("rd1");
    check("rd1_unf", tx_underflow, 1'b0);
    bus_read("rd2");
    check("rd2_unf", tx_underflow, 1'b1);

    // Resync with data queued flushes both FIFOs
    bus_drive(1'b1, 8'h30, 1'b0);
    rx_cnt = 0;
    for (int i = 0; i < 3; i++) bus_write(DW'(8'h61 + i));
    tx_if.data  = 8'hEE;
    tx_if.valid = 1'b1;
    tick(1);
    tx_if.valid = 1'b0;
    check("pre_resync_rx", rx_if.valid, 1'b1);
    resync = 1'b1;
    tick(1);
    resync = 1'b0;
    tick(1);
    exp_q.delete();
    tx_exp_q.delete();
    rx_cnt = 0;
    check("rs_synced", synced, 1'b0);
    check("rs_rx_valid", rx_if.valid, 1'b0);
    check("rs_tx_ready", tx_if.ready, 1'b1);
    check("rs_tx_count", 32'(dut.u_tx_fifo.count_q), 0);

    // Re-sync, load the read register, then reset mid-write
    bus_drive(1'b1, 8'hB8, 1'b0);
    bus_drive(1'b1, 8'h8B, 1'b0);
    check("resync_ok", synced, 1'b1);
    tx_push(8'h3C);
    bus_drive(1'b1, 8'h8B, 1'b1);
    bus_read("rd3c");
    check("pre_rst_unf", tx_underflow, 1'b1);
    bus_drive(1'b1, 8'h8B, 1'b0);
    bus_drive(1'b0, 8'h77, 1'b0);
    bus_clk = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    check("rst_state", 32'(dut.state_q), 32'(ST_HUNT0));
    tick(3);
    reset = 1'b0;
    tick(8);
    check("post_rst_rx", rx_if.valid, 1'b0);
    check("post_rst_synced", synced, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
